// File: rtl/rt_cmd_queue.sv
// Real-time command queue: time-tagged commands stored in arrival order, head
// handed to the pulse synchronizer on request once its start time is within LEAD.
module rt_cmd_queue #(
    parameter int DEPTH = 256,
    parameter int TW    = 64,
    parameter int PW    = 274,
    parameter int LEAD  = 48
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [TW-1:0]            TIME,
    input  logic                     SYS_TIME_UPDATE,
    input  logic                     SPI_WR,
    input  logic [TW-1:0]            CMD_TIME_START,
    input  logic [PW-1:0]            CMD_PAYLOAD,
    input  logic                     REQ_COMMAND,
    output logic                     DATA_WR,
    output logic [TW-1:0]            TIME_START_z,
    output logic [PW-1:0]            PAYLOAD_z,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [7:0]               OVF_CNT,
    output logic [7:0]               STALE_CNT
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = TW + PW;

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, DROP} state_t;

    state_t            state_q, state_d;
    logic              spi_d, spi_dd, req_d, req_dd;
    logic              wr_edge, req_edge, wr_do;
    logic              pending;
    logic              pop, issue, stale;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count_q;
    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     head_q;
    logic [TW:0]       head_ts_x, now_x, win_x;

    assign wr_edge  = spi_d & ~spi_dd;
    assign req_edge = req_d & ~req_dd;
    assign COUNT    = count_q;
    assign EMPTY    = (count_q == '0);
    assign FULL     = (count_q == (AW+1)'(DEPTH));
    // FULL is judged before any pop in the same cycle; a flush swallows the write.
    assign wr_do    = wr_edge & ~FULL & ~SYS_TIME_UPDATE;

    assign head_ts_x = {1'b0, head_q[EW-1 -: TW]};
    assign now_x     = {1'b0, TIME};
    assign win_x     = now_x + (TW+1)'(LEAD);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            spi_d  <= 1'b0;
            spi_dd <= 1'b0;
            req_d  <= 1'b0;
            req_dd <= 1'b0;
        end else begin
            spi_d  <= SPI_WR;
            spi_dd <= spi_d;
            req_d  <= REQ_COMMAND;
            req_dd <= req_d;
        end
    end

    // Storage has no reset; head is re-read every cycle so it tracks rd_ptr.
    always_ff @(posedge CLK) begin
        if (wr_do)
            mem[wr_ptr] <= {CMD_TIME_START, CMD_PAYLOAD};
        head_q <= mem[rd_ptr];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (SYS_TIME_UPDATE) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_do) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + (AW+1)'(wr_do) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pending   <= 1'b0;
            OVF_CNT   <= '0;
            STALE_CNT <= '0;
        end else begin
            if (SYS_TIME_UPDATE)      pending <= 1'b0;
            else if (req_edge)        pending <= 1'b1;
            else if (state_q == ISSUE) pending <= 1'b0;
            if (wr_edge && FULL && !SYS_TIME_UPDATE && OVF_CNT != 8'hFF)
                OVF_CNT <= OVF_CNT + 8'd1;
            if (stale && STALE_CNT != 8'hFF)
                STALE_CNT <= STALE_CNT + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            DATA_WR      <= 1'b0;
            TIME_START_z <= '0;
            PAYLOAD_z    <= '0;
        end else begin
            state_q <= state_d;
            DATA_WR <= issue;
            if (issue)
                {TIME_START_z, PAYLOAD_z} <= head_q;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        issue   = 1'b0;
        stale   = 1'b0;
        case (state_q)
            IDLE:  if (pending && !EMPTY) state_d = CHECK;
            CHECK: begin
                if (head_ts_x <= now_x) begin
                    state_d = DROP;
                end else if (head_ts_x <= win_x) begin
                    state_d = ISSUE;
                    issue   = 1'b1;
                end
            end
            ISSUE: begin
                pop     = 1'b1;
                state_d = IDLE;
            end
            DROP: begin
                pop     = 1'b1;
                stale   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (SYS_TIME_UPDATE) begin
            state_d = IDLE;
            pop     = 1'b0;
            issue   = 1'b0;
            stale   = 1'b0;
        end
    end

endmodule
